// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the L2 request path
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_t;

    localparam int REQ_L1D   = 0;
    localparam int REQ_L1I   = 1;
    localparam int REQ_PF    = 2;
    localparam int LINE_BITS = 256;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr and wrapping
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;

    // first pass covers ptr..N-1, second pass wraps to 0..ptr-1
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && k >= int'(ptr)) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin owner selection for the single L2 port with a watchdog
module l2_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_request,
    input  logic [NUM_REQ*32-1:0]          req_addr,
    input  logic [NUM_REQ-1:0]             req_write_en,
    input  logic [NUM_REQ*LINE_BITS-1:0]   req_write_data,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [LINE_BITS-1:0]           req_rdata,
    output logic [31:0]                    l2_addr,
    output logic                           l2_request,
    output logic                           l2_write_en,
    output logic [LINE_BITS-1:0]           l2_write_data,
    input  logic [LINE_BITS-1:0]           l2_data,
    input  logic                           l2_done,
    output logic                           timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state, state_d;
    logic [PW-1:0]        ptr, owner, win_idx;
    logic [NUM_REQ-1:0]   win;
    logic [31:0]          win_addr;
    logic                 win_we;
    logic [LINE_BITS-1:0] win_data;
    logic [7:0]           wdog;
    logic                 start, done_hit, wd_hit;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req   (req_request),
        .ptr   (ptr),
        .grant (win)
    );

    assign req_done  = req_grant & {NUM_REQ{l2_done}};
    assign req_rdata = l2_data;

    // encode the one-hot winner and mux its request fields
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_we   = 1'b0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                win_addr = req_addr[i*32 +: 32];
                win_we   = req_write_en[i];
                win_data = req_write_data[i*LINE_BITS +: LINE_BITS];
            end
        end
    end

    // next state: l2_done wins over a watchdog expiry in the same cycle
    always_comb begin
        start    = (state == IDLE) && |req_request;
        done_hit = (state == BUSY) && l2_done;
        wd_hit   = (state == BUSY) && !l2_done && (wdog == 8'(TIMEOUT));
        state_d  = start                ? BUSY  :
                   (done_hit || wd_hit) ? DRAIN :
                   (state == DRAIN)     ? IDLE  : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // grant, L2 request latches, round-robin pointer and watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            req_grant     <= '0;
            owner         <= '0;
            ptr           <= '0;
            l2_request    <= 1'b0;
            l2_write_en   <= 1'b0;
            l2_addr       <= '0;
            l2_write_data <= '0;
            timeout_err   <= 1'b0;
            wdog          <= '0;
        end else if (start) begin
            req_grant     <= win;
            owner         <= win_idx;
            l2_request    <= 1'b1;
            l2_write_en   <= win_we;
            l2_addr       <= line_align(win_addr);
            l2_write_data <= win_data;
            wdog          <= '0;
        end else if (done_hit || wd_hit) begin
            req_grant   <= '0;
            l2_request  <= 1'b0;
            l2_write_en <= 1'b0;
            timeout_err <= timeout_err | wd_hit;
            if (done_hit)
                ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end else if (state == BUSY) begin
            wdog <= wdog + 8'd1;
        end
    end

endmodule
